seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller: N digits, built-in refresh divider, hex decoding, per-digit blanking, leading-zero suppression, PWM brightness and tear-free frame-synchronous update. Sits between board-level logic and the segment/anode pins. Replaces the fixed-width display plus external strobe generator pair.

## Interface
- N_DIGITS, 8: digit count, 2..16
- DIV_W, 16: refresh divider width; digit slot = 2^DIV_W cycles
- BRIGHT_W, 3: brightness code width, 1..DIV_W
- SEG_ACTIVE_LOW, 1: abcdefg and dot driven active-low when 1
- DIG_ACTIVE_LOW, 1: anodes driven active-low when 1

- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- num  in  4*N_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant
- dots  in  N_DIGITS  decimal point per digit
- blank  in  N_DIGITS  force digit off
- lz_en  in  1  leading-zero suppression enable
- load  in  1  capture num/dots/blank/lz_en into the shadow register
- brightness  in  BRIGHT_W  duty code, applied immediately
- abcdefg  out  7  segments; bit 6 = a
- dot  out  1  decimal point
- anodes  out  N_DIGITS  digit enables, one-hot when lit
- frame_done  out  1  one-cycle pulse at frame boundary

## Operation
- Divider: free-running DIV_W-bit up-counter. tick = counter all-ones.
- Digit index: advances on tick; wraps N_DIGITS-1 -> 0. boundary = tick while index == N_DIGITS-1.
- Shadow/active registers: load captures inputs into shadow and sets pending. On boundary with pending set, active <= shadow and pending clears. Load and boundary in the same cycle: inputs go straight to active, pending clears. A load while pending overwrites the shadow (last load wins).
- Leading-zero suppression, when active lz_en = 1: digit i is suppressed if its nibble and all higher nibbles are 0. Digit 0 is never suppressed. Blank bits do not count as zero.
- A digit is dark if blanked or suppressed: segments and dot off. Its anode is still driven, so PWM stays uniform.
- Brightness: anode enabled while div[DIV_W-1 -: BRIGHT_W] <= brightness. Duty = (brightness+1)/2^BRIGHT_W; the maximum code gives 100 %. When the anode is off, segments are also forced off.
- Decode: standard hex 0-F (0 = 7'b1111110, 4 = 7'b0110011, b/d lowercase), active-high internally, then inverted per parameter.

## Timing
- Reset values:
  - divider, index, pending and active register all 0
  - anodes, abcdefg and dot at inactive level (all 1 when active-low)
  - frame_done 0
- All outputs registered. Pins reflect index/divider state with 1-cycle latency.
- frame_done asserts in the cycle after boundary, coincident with the first cycle of digit 0 using the new active data.
- Frame length = N_DIGITS * 2^DIV_W cycles exactly. No dead slots.
- Brightness change takes effect on the next cycle's compare; no frame synchronisation.
- rst mid-frame: immediate return to reset values. A pending load is discarded.
- Load-to-display latency: at most one frame + 1 cycle.

## Structure
- Package seg7_pkg:
  - hex-to-segment function
  - segment constants (SEG_BLANK, SEG_MINUS)
  - clog2 helper for the index width
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit active-high pattern, shared with other display blocks.
- Divider, index, shadow/active registers, suppression mask and output register stay in the top.

## Test plan
All scenarios use N_DIGITS=4, DIV_W=2, BRIGHT_W=2, active-low.
- Reset: assert rst mid-run -> anodes 4'b1111, abcdefg 7'h7F, dot 1, frame_done 0 asynchronously; after release, the first anode 4'b1110 appears 1 cycle after the first clock.
- Scan: load num=16'h1234, brightness=3 -> after frame_done, anodes cycle 1110/1101/1011/0111, 4 cycles each. The digit 0 slot shows abcdefg 7'b1001100 ('4'). A frame is 16 cycles.
- Leading zeros: num=16'h0050, lz_en=1 -> digits 3 and 2 dark, digit 1 '5', digit 0 '0'. num=0 -> only digit 0 shows '0'. lz_en=0 -> all four digits show their nibble.
- Brightness: brightness=0 -> each anode active 1 of its 4 cycles. brightness=2 -> 3 of 4. Segments are inactive whenever the anode is inactive.
- Tear-free update:
  - load 16'hAAAA mid-frame -> display unchanged until the next frame_done, then shows AAAA.
  - load coincident with boundary -> new data shows in the immediately following frame.
  - two loads in one frame -> second value shown.
- Blank/dots: blank=4'b0100, dots=4'b0001 -> digit 2 fully dark, digit 0 dot low, other dots high.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex decode table, segment constants and
// an index-width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  // Bits needed to index `value` items; never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return (w == 0) ? 1 : w;
  endfunction

  // Active-high abcdefg pattern, bit 6 = a; b and d are lowercase.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous update,
// leading-zero suppression and PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned BRIGHT_W       = 3,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] num,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            abcdefg,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = clog2(N_DIGITS);
  localparam int unsigned NUM_W = 4 * N_DIGITS;
  localparam logic [6:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DOT_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;
  localparam logic [N_DIGITS-1:0] DIG_ONE  = N_DIGITS'(1);

  logic [DIV_W-1:0]    div_q;
  logic [IDX_W-1:0]    idx_q;
  logic                tick;
  logic                boundary;

  logic [NUM_W-1:0]    sh_num, act_num;
  logic [N_DIGITS-1:0] sh_dots, act_dots;
  logic [N_DIGITS-1:0] sh_blank, act_blank;
  logic                sh_lz, act_lz;
  logic                pending;

  logic [N_DIGITS-1:0] supp;
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic                lit;
  logic                dark;
  logic [6:0]          seg_c;
  logic                dot_c;
  logic [N_DIGITS-1:0] an_c;

  assign tick     = &div_q;
  assign boundary = tick && (idx_q == IDX_W'(N_DIGITS - 1));

  // Refresh divider and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
      if (tick) idx_q <= boundary ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow captures loads; active only changes at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_num    <= '0;
      sh_dots   <= '0;
      sh_blank  <= '0;
      sh_lz     <= 1'b0;
      act_num   <= '0;
      act_dots  <= '0;
      act_blank <= '0;
      act_lz    <= 1'b0;
      pending   <= 1'b0;
    end else if (load && boundary) begin
      sh_num    <= num;
      sh_dots   <= dots;
      sh_blank  <= blank;
      sh_lz     <= lz_en;
      act_num   <= num;
      act_dots  <= dots;
      act_blank <= blank;
      act_lz    <= lz_en;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        sh_num   <= num;
        sh_dots  <= dots;
        sh_blank <= blank;
        sh_lz    <= lz_en;
        pending  <= 1'b1;
      end
      if (boundary && pending) begin
        act_num   <= sh_num;
        act_dots  <= sh_dots;
        act_blank <= sh_blank;
        act_lz    <= sh_lz;
        pending   <= 1'b0;
      end
    end
  end

  // A digit is suppressed when it and every higher nibble are zero.
  always_comb begin : lz_mask
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      zero_run = zero_run & (act_num[4*i +: 4] == 4'h0);
      supp[i]  = act_lz & zero_run;
    end
  end

  assign cur_nib = act_num[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg_c  (dec_seg)
  );

  always_comb begin
    lit   = (div_q[DIV_W-1 -: BRIGHT_W] <= brightness);
    dark  = act_blank[idx_q] | supp[idx_q];
    seg_c = (lit && !dark) ? dec_seg : SEG_BLANK;
    dot_c = lit && !dark && act_dots[idx_q];
    an_c  = lit ? (DIG_ONE << idx_q) : '0;
  end

  // Pin register: polarity applied here so reset sits at the inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abcdefg    <= SEG_OFF;
      dot        <= DOT_OFF;
      anodes     <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      abcdefg    <= seg_c ^ SEG_OFF;
      dot        <= dot_c ^ DOT_OFF;
      anodes     <= an_c ^ DIG_OFF;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-cycle pin expectations from a
// frame-level reference model, checked by an independent monitor.
module tb_seg7_scan_ctrl;

  localparam int unsigned N        = 4;
  localparam int unsigned DIV_W    = 2;
  localparam int unsigned BRIGHT_W = 2;
  localparam int unsigned SLOT     = 1 << DIV_W;
  localparam int unsigned FRAME    = N * SLOT;

  localparam logic [6:0] HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic        lz;
  } rec_t;

  typedef struct packed {
    logic [3:0] anodes;
    logic [6:0] seg;
    logic       dot;
    logic       fd;
  } pins_t;

  typedef struct {
    int unsigned cyc;
    pins_t       p;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [15:0]         num = '0;
  logic [3:0]          dots = '0;
  logic [3:0]          blank = '0;
  logic                lz_en = 1'b0;
  logic                load = 1'b0;
  logic [BRIGHT_W-1:0] brightness = '1;
  logic [6:0]          abcdefg;
  logic                dot;
  logic [3:0]          anodes;
  logic                frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned s = 0;
  rec_t        latest = '0;
  rec_t        frame_data = '0;
  exp_t        q [$];
  exp_t        mon_e;
  pins_t       mon_a;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS       (N),
    .DIV_W          (DIV_W),
    .BRIGHT_W       (BRIGHT_W),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .num        (num),
    .dots       (dots),
    .blank      (blank),
    .lz_en      (lz_en),
    .load       (load),
    .brightness (brightness),
    .abcdefg    (abcdefg),
    .dot        (dot),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  // Expected pins one cycle after a given state cycle, from the display rules.
  function automatic pins_t model(int unsigned cyc, rec_t f, logic [BRIGHT_W-1:0] br);
    pins_t       e;
    int unsigned d;
    int unsigned p;
    logic        on;
    logic        dark;
    logic [3:0]  nib;
    logic [6:0]  seg;
    d    = (cyc / SLOT) % N;
    p    = cyc % SLOT;
    nib  = 4'(f.num >> (4 * d));
    on   = (p >> (DIV_W - BRIGHT_W)) <= 32'(br);
    dark = f.blank[d] || (f.lz && d != 0 && (f.num >> (4 * d)) == 16'h0);
    seg  = (on && !dark) ? HEX[nib] : 7'h00;
    e.anodes = on ? ~(4'b0001 << d) : 4'hF;
    e.seg    = ~seg;
    e.dot    = ~(on && !dark && f.dots[d]);
    e.fd     = (cyc % FRAME) == FRAME - 1;
    return e;
  endfunction

  // Each display frame shows the most recent load issued before it began.
  task automatic step();
    exp_t e;
    if (s % FRAME == 0) frame_data = latest;
    e.cyc = s;
    e.p   = model(s, frame_data, brightness);
    q.push_back(e);
    if (load) latest = '{num, dots, blank, lz_en};
    @(negedge clk);
    s++;
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic goto_phase(int unsigned ph);
    while (s % FRAME != ph) step();
  endtask

  task automatic do_load(logic [15:0] n_, logic [3:0] d_, logic [3:0] b_, logic lz_);
    num = n_; dots = d_; blank = b_; lz_en = lz_; load = 1'b1;
    step();
    load = 1'b0;
    num = 16'($urandom); dots = 4'($urandom); blank = 4'($urandom); lz_en = 1'($urandom);
  endtask

  task automatic check_reset(string name);
    pins_t a;
    a = '{anodes, abcdefg, dot, frame_done};
    n_checks++;
    if (a !== pins_t'({4'hF, 7'h7F, 1'b1, 1'b0})) begin
      n_errors++;
      $display("FAIL %s: got an=%b seg=%b dot=%b fd=%b, want an=1111 seg=1111111 dot=1 fd=0",
               name, anodes, abcdefg, dot, frame_done);
    end
  endtask

  task automatic restart();
    rst = 1'b0; s = 0; latest = '0; frame_data = '0;
  endtask

  // Monitor: every clocked cycle the pins are compared with the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = '{anodes, abcdefg, dot, frame_done};
      n_checks++;
      if (mon_a !== mon_e.p) begin
        n_errors++;
        $display("FAIL pins state_cyc=%0d: got an=%b seg=%b dot=%b fd=%b, want an=%b seg=%b dot=%b fd=%b",
                 mon_e.cyc, mon_a.anodes, mon_a.seg, mon_a.dot, mon_a.fd,
                 mon_e.p.anodes, mon_e.p.seg, mon_e.p.dot, mon_e.p.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    restart();
    #1 check_reset("post_release");

    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    steps(40);

    do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    steps(32);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    steps(32);
    do_load(16'h0050, 4'b0000, 4'b0000, 1'b0);
    steps(32);

    brightness = 2'd0; steps(20);
    brightness = 2'd2; steps(20);
    brightness = 2'd3;

    goto_phase(6);
    do_load(16'hAAAA, 4'b0000, 4'b0000, 1'b0);
    steps(30);
    goto_phase(FRAME - 1);
    do_load(16'h5A3C, 4'b0000, 4'b0000, 1'b0);
    steps(20);
    goto_phase(2);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    steps(3);
    do_load(16'h9F0E, 4'b0000, 4'b0000, 1'b0);
    steps(30);

    do_load(16'h0123, 4'b0001, 4'b0100, 1'b0);
    steps(32);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) brightness = BRIGHT_W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        num   = 16'(32'($urandom) >> (4 * $urandom_range(0, 4)));
        dots  = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lz_en = 1'($urandom);
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end

    brightness = 2'd3;
    goto_phase(8);
    do_load(16'hBEEF, 4'b1111, 4'b0000, 1'b0);
    rst = 1'b1;
    #1 check_reset("async_reset");
    q.delete();
    @(negedge clk);
    check_reset("reset_clocked");
    restart();
    #1 check_reset("second_release");
    steps(40);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) brightness = BRIGHT_W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        num   = 16'(32'($urandom) >> (4 * $urandom_range(0, 4)));
        dots  = 4'($urandom);
        blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        lz_en = 1'($urandom);
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end

    @(posedge clk);
    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
